// File: rtl/spi_pwm_controller.sv
// SPI mode-0 master that serialises one 16-bit {R/W, addr[6:0], data[7:0]} frame per accepted command.
// Latency: ncs falls one cycle after acceptance and stays low 33*HALF_PERIOD cycles; cmd_ready returns after CS_GAP.
module spi_pwm_controller #(
    parameter int HALF_PERIOD = 4,
    parameter int CS_GAP      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       copi,
    output logic       ncs
);
    localparam int HW = $clog2(HALF_PERIOD + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          copi_q, copi_d;
    logic          ncs_q, ncs_d;
    logic          done_q, done_d;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        gcnt_d  = gcnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        copi_d  = copi_q;
        ncs_d   = ncs_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = SETUP;
                    shreg_d = {cmd_write, cmd_addr, cmd_data};
                    copi_d  = cmd_write;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    hcnt_d  = HALF_LAST;
                    bit_d   = 4'd15;
                end
            end
            SETUP, SHIFT_LO: begin
                if (hcnt_q == '0) begin
                    state_d = SHIFT_HI;
                    sclk_d  = 1'b1;
                    hcnt_d  = HALF_LAST;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            SHIFT_HI: begin
                if (hcnt_q == '0) begin
                    sclk_d = 1'b0;
                    hcnt_d = HALF_LAST;
                    if (bit_q == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        // next bit presented on the falling edge, half a period before the peripheral samples it
                        state_d = SHIFT_LO;
                        copi_d  = shreg_q[14];
                        shreg_d = {shreg_q[14:0], 1'b0};
                        bit_d   = bit_q - 4'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            HOLD: begin
                if (hcnt_q == '0) begin
                    state_d = GAP;
                    ncs_d   = 1'b1;
                    done_d  = 1'b1;
                    gcnt_d  = GAP_LAST;
                end else begin
                    hcnt_d = hcnt_q - 1'b1;
                end
            end
            GAP: begin
                if (gcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            gcnt_q  <= '0;
            bit_q   <= 4'd0;
            shreg_q <= 16'h0000;
            sclk_q  <= 1'b0;
            copi_q  <= 1'b0;
            ncs_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            gcnt_q  <= gcnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            copi_q  <= copi_d;
            ncs_q   <= ncs_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;
endmodule

// File: tb/tb_spi_pwm_controller.sv
// Directed bench for spi_pwm_controller: captures COPI on each SCLK rise and decodes frames into a peripheral register model.
module tb_spi_pwm_controller;
    localparam int HP  = 4;
    localparam int GAP = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       busy, done, sclk, copi, ncs;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] uo_out  = 8'h00;
    logic [7:0] uio_out = 8'h00;

    spi_pwm_controller #(.HALF_PERIOD(HP), .CS_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .busy(busy), .done(done), .sclk(sclk), .copi(copi), .ncs(ncs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling clk edge; returns just after the falling edge where busy is low again.
    task automatic do_frame(input string tag, input logic w, input logic [6:0] a, input logic [7:0] d,
                            input bit hold, input bit perturb, input int abort_at);
        logic [15:0] rx = 16'h0000;
        logic        prev_sclk = 1'b0;
        int          rises = 0, lowc = 0, gap_hi = 0, dones = 0, done_bad = 0, rdy_bad = 0;
        bit          finished = 0, aborted = 0, accepted = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("%s_accept", tag), {31'd0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        if (perturb) begin
            cmd_valid = 1'b1;
            cmd_write = ~w;
            cmd_addr  = ~a;
            cmd_data  = ~d;
        end
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk($sformatf("%s_first_ncs", tag), {31'd0, ncs}, 32'd0);
                chk($sformatf("%s_first_copi", tag), {31'd0, copi}, {31'd0, w});
                chk($sformatf("%s_first_busy_rdy", tag), {30'd0, busy, cmd_ready}, 32'd2);
            end
            if (sclk && !prev_sclk) begin
                rx = {rx[14:0], copi};
                rises++;
            end
            prev_sclk = sclk;
            if (abort_at != 0 && rises == abort_at) begin
                aborted = 1;
                break;
            end
            if (!ncs) lowc++;
            else if (lowc > 0) gap_hi++;
            if (done) begin
                dones++;
                if (!(ncs && gap_hi == 1)) done_bad++;
            end
            if (busy && cmd_ready) rdy_bad++;
            if (!busy) begin
                finished = 1;
                break;
            end
        end
        if (perturb) cmd_valid = 1'b0;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            chk($sformatf("%s_rst_pins", tag), {28'd0, ncs, sclk, copi, done}, 32'h8);
            chk($sformatf("%s_rst_busy_rdy", tag), {30'd0, busy, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (i == 4) rst_n = 1'b1;
                if (done || !ncs) dones++;
            end
            chk($sformatf("%s_no_done", tag), dones, 32'd0);
        end else begin
            chk($sformatf("%s_finished", tag), {31'd0, finished}, 32'd1);
            chk($sformatf("%s_rx", tag), {16'd0, rx}, {16'd0, w, a, d});
            chk($sformatf("%s_rises", tag), rises, 32'd16);
            chk($sformatf("%s_ncs_low", tag), lowc, 32'd132);
            chk($sformatf("%s_done_cnt", tag), dones, 32'd1);
            chk($sformatf("%s_done_pos", tag), done_bad, 32'd0);
            chk($sformatf("%s_gap_hi", tag), gap_hi, 32'd9);
            chk($sformatf("%s_rdy_busy", tag), rdy_bad, 32'd0);
            if (rx[15] && rx[14:8] == 7'h00) uo_out = rx[7:0];
            if (rx[15] && rx[14:8] == 7'h01) uio_out = rx[7:0];
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 7'h00;
        cmd_data  = 8'h00;
        #12;
        chk("reset_pins", {28'd0, ncs, sclk, copi, done}, 32'h8);
        chk("reset_busy_rdy", {30'd0, busy, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_frame("t1_wr00_f0", 1'b1, 7'h00, 8'hF0, 0, 0, 0);
        do_frame("t2a_hold", 1'b1, 7'h01, 8'h3C, 1, 0, 0);
        do_frame("t2b_next", 1'b1, 7'h02, 8'hC3, 0, 0, 0);
        do_frame("t3_read7f", 1'b0, 7'h7F, 8'h55, 0, 0, 0);
        do_frame("t4_abort", 1'b1, 7'h05, 8'hAA, 0, 0, 5);
        do_frame("t4_clean", 1'b1, 7'h06, 8'h81, 0, 0, 0);
        do_frame("t5_perturb", 1'b1, 7'h03, 8'h5A, 0, 1, 0);
        repeat (5) @(negedge clk);
        chk("t5_no_capture", {30'd0, busy, ncs}, 32'd1);
        do_frame("t6_uo", 1'b1, 7'h00, 8'hFF, 0, 0, 0);
        do_frame("t6_uio", 1'b1, 7'h01, 8'h0F, 0, 0, 0);
        chk("t6_uo_out", {24'd0, uo_out}, 32'hFF);
        chk("t6_uio_out", {24'd0, uio_out}, 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
